// File: rtl/dmem_lsu_pkg.sv
// Shared op codes, memory width encodings, exception codes and FSM states for the load/store unit.
package dmem_lsu_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned WIDTH_W = 2;
  localparam int unsigned EXC_W   = 5;

  localparam logic [OP_W-1:0] LSU_LB  = 3'd0;
  localparam logic [OP_W-1:0] LSU_LBU = 3'd1;
  localparam logic [OP_W-1:0] LSU_LH  = 3'd2;
  localparam logic [OP_W-1:0] LSU_LHU = 3'd3;
  localparam logic [OP_W-1:0] LSU_LW  = 3'd4;
  localparam logic [OP_W-1:0] LSU_SB  = 3'd5;
  localparam logic [OP_W-1:0] LSU_SH  = 3'd6;
  localparam logic [OP_W-1:0] LSU_SW  = 3'd7;

  localparam logic [WIDTH_W-1:0] WIDTH_BYTE = 2'b00;
  localparam logic [WIDTH_W-1:0] WIDTH_HALF = 2'b01;
  localparam logic [WIDTH_W-1:0] WIDTH_WORD = 2'b10;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational op decode: access width, store flag, alignment check and load-data extension.
module lsu_align
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]    op,
  input  logic [1:0]         addr_lo,
  input  logic [DATA_W-1:0]  raw,
  output logic               misaligned,
  output logic               is_store,
  output logic [WIDTH_W-1:0] width,
  output logic [DATA_W-1:0]  ext
);

  always_comb begin
    width    = WIDTH_WORD;
    ext      = raw;
    is_store = 1'b0;
    unique case (op)
      LSU_LB:  begin width = WIDTH_BYTE; ext = {{(DATA_W-8){raw[7]}}, raw[7:0]}; end
      LSU_LBU: begin width = WIDTH_BYTE; ext = {{(DATA_W-8){1'b0}}, raw[7:0]}; end
      LSU_LH:  begin width = WIDTH_HALF; ext = {{(DATA_W-16){raw[15]}}, raw[15:0]}; end
      LSU_LHU: begin width = WIDTH_HALF; ext = {{(DATA_W-16){1'b0}}, raw[15:0]}; end
      LSU_LW:  begin width = WIDTH_WORD; ext = raw; end
      LSU_SB:  begin width = WIDTH_BYTE; is_store = 1'b1; end
      LSU_SH:  begin width = WIDTH_HALF; is_store = 1'b1; end
      LSU_SW:  begin width = WIDTH_WORD; is_store = 1'b1; end
      default: begin width = WIDTH_WORD; end
    endcase
  end

  // Bytes are always aligned; halves need addr[0]=0, words addr[1:0]=0.
  always_comb begin
    misaligned = 1'b0;
    if (width == WIDTH_HALF)      misaligned = addr_lo[0];
    else if (width == WIDTH_WORD) misaligned = (addr_lo != 2'b00);
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: accepts one MEM-stage request, performs a single-cycle DMEM access
// (or raises an address-error), and returns a one-cycle response.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OP_W-1:0]    req_op,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic               kill,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_exc,
  output logic [EXC_W-1:0]   resp_exc_code,
  output logic [ADDR_W-1:0]  resp_badvaddr,
  output logic               DMEM_ena,
  output logic               DMEM_W,
  output logic               DMEM_R,
  output logic [WIDTH_W-1:0] DMEM_width,
  output logic [ADDR_W-1:0]  DM_addr,
  output logic [DATA_W-1:0]  DM_wdata,
  input  logic [DATA_W-1:0]  DM_rdata
);

  state_t             state;
  logic [OP_W-1:0]    op_q;
  logic               dmem_w_q;
  logic               dmem_r_q;
  logic               resp_valid_q;
  logic               resp_exc_q;
  logic [EXC_W-1:0]   resp_code_q;
  logic [ADDR_W-1:0]  resp_badvaddr_q;
  logic [DATA_W-1:0]  resp_rdata_q;

  logic [OP_W-1:0]    dec_op;
  logic               misaligned;
  logic               is_store;
  logic [WIDTH_W-1:0] width;
  logic [DATA_W-1:0]  ext;
  logic               suppress;

  // Decode the incoming request while idle, the latched op while accessing.
  assign dec_op = (state == ST_IDLE) ? req_op : op_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .op         (dec_op),
    .addr_lo    (req_addr[1:0]),
    .raw        (DM_rdata),
    .misaligned (misaligned),
    .is_store   (is_store),
    .width      (width),
    .ext        (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      op_q            <= '0;
      DMEM_ena        <= 1'b0;
      dmem_w_q        <= 1'b0;
      dmem_r_q        <= 1'b0;
      DMEM_width      <= '0;
      DM_addr         <= '0;
      DM_wdata        <= '0;
      resp_valid_q    <= 1'b0;
      resp_exc_q      <= 1'b0;
      resp_code_q     <= '0;
      resp_badvaddr_q <= '0;
      resp_rdata_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid && !kill) begin
            op_q <= req_op;
            if (misaligned) begin
              state           <= ST_FAULT;
              resp_valid_q    <= 1'b1;
              resp_exc_q      <= 1'b1;
              resp_code_q     <= is_store ? EXC_ADES : EXC_ADEL;
              resp_badvaddr_q <= req_addr;
            end else begin
              state      <= ST_ACCESS;
              DMEM_ena   <= 1'b1;
              dmem_w_q   <= is_store;
              dmem_r_q   <= !is_store;
              DMEM_width <= width;
              DM_addr    <= req_addr;
              DM_wdata   <= req_wdata;
            end
          end
        end
        ST_ACCESS: begin
          DMEM_ena   <= 1'b0;
          dmem_w_q   <= 1'b0;
          dmem_r_q   <= 1'b0;
          DMEM_width <= '0;
          DM_addr    <= '0;
          DM_wdata   <= '0;
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= is_store ? '0 : ext;
          end
        end
        default: begin
          state           <= ST_IDLE;
          resp_valid_q    <= 1'b0;
          resp_exc_q      <= 1'b0;
          resp_code_q     <= '0;
          resp_badvaddr_q <= '0;
          resp_rdata_q    <= '0;
        end
      endcase
    end
  end

  // A kill (or reset) must squash the strobes within the access cycle itself.
  assign DMEM_W = dmem_w_q & ~kill & ~rst;
  assign DMEM_R = dmem_r_q & ~kill & ~rst;

  assign req_ready = (state == ST_IDLE);

  assign suppress      = (state == ST_FAULT) && kill;
  assign resp_valid    = resp_valid_q & ~suppress;
  assign resp_exc      = resp_exc_q & ~suppress;
  assign resp_exc_code = resp_code_q & {EXC_W{~suppress}};
  assign resp_badvaddr = resp_badvaddr_q & {ADDR_W{~suppress}};
  assign resp_rdata    = resp_rdata_q & {DATA_W{~suppress}};

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array DMEM model plus a reference byte image used to predict results.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        kill;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic [31:0] resp_badvaddr;
  logic        DMEM_ena;
  logic        DMEM_W;
  logic        DMEM_R;
  logic [1:0]  DMEM_width;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [31:0] DM_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  dmem    [256];
  logic [7:0]  ref_mem [256];
  logic        mem_fill;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .kill(kill),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_exc_code(resp_exc_code), .resp_badvaddr(resp_badvaddr),
    .DMEM_ena(DMEM_ena), .DMEM_W(DMEM_W), .DMEM_R(DMEM_R), .DMEM_width(DMEM_width),
    .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata)
  );

  // Memory-side model: combinational zero-extended read, posedge lane-placed write.
  always_comb begin
    logic [7:0] a;
    a = DM_addr[7:0];
    mem_rd = '0;
    case (DMEM_width)
      2'b00:   mem_rd = {24'd0, dmem[a]};
      2'b01:   mem_rd = {16'd0, dmem[8'(a + 1)], dmem[a]};
      default: mem_rd = {dmem[8'(a + 3)], dmem[8'(a + 2)], dmem[8'(a + 1)], dmem[a]};
    endcase
  end
  assign DM_rdata = (DMEM_ena && DMEM_R) ? mem_rd : 32'bz;

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i * 37 + 11);
    end else if (DMEM_ena && DMEM_W) begin
      dmem[DM_addr[7:0]] <= DM_wdata[7:0];
      if (DMEM_width != 2'b00) dmem[8'(DM_addr[7:0] + 1)] <= DM_wdata[15:8];
      if (DMEM_width == 2'b10) begin
        dmem[8'(DM_addr[7:0] + 2)] <= DM_wdata[23:16];
        dmem[8'(DM_addr[7:0] + 3)] <= DM_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] op);
    if (op == LSU_LB || op == LSU_LBU || op == LSU_SB) return 1;
    if (op == LSU_LH || op == LSU_LHU || op == LSU_SH) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] size_code(input int size);
    if (size == 1) return 2'b00;
    if (size == 2) return 2'b01;
    return 2'b10;
  endfunction

  // Little-endian value from the reference image, sign-adjusted arithmetically for lb/lh.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] v;
    int size;
    size = op_size(op);
    v = 0;
    for (int i = 0; i < size; i++) v = v + (32'(ref_mem[8'(addr + i)]) << (8 * i));
    if (op == LSU_LB && v >= 128)   v = v - 256;
    if (op == LSU_LH && v >= 32768) v = v - 65536;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < op_size(op); i++) ref_mem[8'(addr + i)] = 8'(data >> (8 * i));
  endtask

  // One request end to end; do_kill raises kill during the access/fault cycle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit do_kill);
    int  size;
    bit  store;
    bit  fault;
    logic [31:0] exp_rd;
    size  = op_size(op);
    store = (op >= LSU_SB);
    fault = (addr % size) != 0;
    exp_rd = store ? 32'd0 : ref_load(op, addr);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (do_kill) kill = 1'b1;
    #1;
    if (fault) begin
      check("flt_valid", 32'(resp_valid), 32'(!do_kill));
      check("flt_exc", 32'(resp_exc), 32'(!do_kill));
      check("flt_code", 32'(resp_exc_code), do_kill ? 32'd0 : (store ? 32'd5 : 32'd4));
      check("flt_badva", resp_badvaddr, do_kill ? 32'd0 : addr);
      check("flt_rdata", resp_rdata, 32'd0);
      check("flt_ena", 32'({DMEM_ena, DMEM_R, DMEM_W}), 32'd0);
    end else begin
      check("acc_ena", 32'(DMEM_ena), 32'd1);
      check("acc_width", 32'(DMEM_width), 32'(size_code(size)));
      check("acc_addr", DM_addr, addr);
      check("acc_wdata", DM_wdata, wdata);
      check("acc_r", 32'(DMEM_R), 32'(!store && !do_kill));
      check("acc_w", 32'(DMEM_W), 32'(store && !do_kill));
      check("acc_rv", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    kill = 1'b0;
    if (fault || do_kill) begin
      check("post_rv", 32'(resp_valid), 32'd0);
      check("post_ready", 32'(req_ready), 32'd1);
      check("post_ena", 32'(DMEM_ena), 32'd0);
    end else begin
      if (store) ref_store(op, addr, wdata);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_exc", 32'({resp_exc, resp_exc_code}), 32'd0);
      check("resp_badva", resp_badvaddr, 32'd0);
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_ena", 32'(DMEM_ena), 32'd0);
      @(negedge clk);
      check("end_rv", 32'(resp_valid), 32'd0);
      check("end_ready", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp"}, 32'({resp_valid, resp_exc, resp_exc_code}), 32'd0);
    check({tag, "_rsp_data"}, resp_rdata | resp_badvaddr, 32'd0);
    check({tag, "_dmem"}, 32'({DMEM_ena, DMEM_W, DMEM_R, DMEM_width}), 32'd0);
    check({tag, "_dm_bus"}, DM_addr | DM_wdata, 32'd0);
  endtask

  initial begin
    int diffs;
    logic [2:0]  op;
    logic [31:0] addr;
    rst = 1'b1; mem_fill = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; kill = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    req_valid = 1'b1; req_op = LSU_SW;
    repeat (3) @(negedge clk);
    check_quiet("rst_held");
    req_valid = 1'b0;
    rst = 1'b0; mem_fill = 1'b0;
    @(negedge clk);
    check_quiet("rst_rel");

    do_op(LSU_SW, 32'h10, 32'h12345678, 1'b0);
    do_op(LSU_LW, 32'h10, 32'h0, 1'b0);
    check("t1_lw", ref_load(LSU_LW, 32'h10), 32'h12345678);
    do_op(LSU_SB, 32'h21, 32'h80, 1'b0);
    do_op(LSU_LB, 32'h21, 32'h0, 1'b0);
    do_op(LSU_LBU, 32'h21, 32'h0, 1'b0);
    do_op(LSU_SW, 32'h40, 32'h0, 1'b0);
    do_op(LSU_SH, 32'h42, 32'hBEEF, 1'b0);
    do_op(LSU_LW, 32'h40, 32'h0, 1'b0);
    do_op(LSU_LH, 32'h42, 32'h0, 1'b0);
    do_op(LSU_LHU, 32'h42, 32'h0, 1'b0);
    do_op(LSU_LW, 32'h42, 32'h0, 1'b0);
    do_op(LSU_SH, 32'h43, 32'h5555, 1'b0);
    do_op(LSU_LW, 32'h40, 32'h0, 1'b0);
    do_op(LSU_SW, 32'h80, 32'hDEADBEEF, 1'b1);
    do_op(LSU_LW, 32'h80, 32'h0, 1'b0);
    do_op(LSU_LW, 32'h81, 32'h0, 1'b1);

    // req_valid together with kill while idle must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = LSU_SW; req_addr = 32'h20; kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check_quiet("idle_kill");

    // Reset during the access cycle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_op = LSU_SW; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst_acc_w", 32'(DMEM_W), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_quiet("rst_acc");
    do_op(LSU_LW, 32'h10, 32'h0, 1'b0);

    repeat (250) begin
      op   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) addr = addr & ~(32'(op_size(op)) - 1);
      do_op(op, addr, $urandom, $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) diffs++;
    check("mem_image", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
